// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: classifies the D instruction, tracks destination/Tnew of
// the in-flight stages and derives the D stall plus rs/rt forwarding selects.
module hazard_scoreboard #(
    parameter  int NUM_STAGES = 3,
    localparam int FWD_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_d,
    input  logic             hold,
    output logic [3:0]       class_d,
    output logic             stall,
    output logic [FWD_W-1:0] fwd_rs_sel,
    output logic [FWD_W-1:0] fwd_rt_sel
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;

    typedef enum logic [3:0] {
        CLS_OTHER  = 4'd0,
        CLS_R      = 4'd1,
        CLS_IMM    = 4'd2,
        CLS_BRANCH = 4'd3,
        CLS_LOAD   = 4'd4,
        CLS_JR     = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_STORE  = 4'd7,
        CLS_J      = 4'd8
    } class_e;

    // A stage with dst == 0 is a bubble; rem counts cycles until its result exists.
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] rem;
    } stage_t;

    stage_t [NUM_STAGES-1:0] stage_q;

    class_e     cls;
    logic       rs_used;
    logic       rt_used;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic [4:0] dst_d;
    logic [1:0] tnew_d;
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_shamt;

    assign op           = instr_d[31:26];
    assign funct        = instr_d[5:0];
    assign unused_shamt = ^instr_d[10:6];
    assign class_d      = cls;

    always_comb begin
        cls     = CLS_OTHER;
        rs_used = 1'b0;
        rt_used = 1'b0;
        rs_tuse = 2'd0;
        rt_tuse = 2'd0;
        dst_d   = 5'd0;
        tnew_d  = 2'd0;
        case (op)
            OP_SPECIAL: begin
                if (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLL) begin
                    cls     = CLS_R;
                    rs_used = (funct != FN_SLL);
                    rt_used = 1'b1;
                    rs_tuse = 2'd1;
                    rt_tuse = 2'd1;
                    dst_d   = instr_d[15:11];
                    tnew_d  = 2'd1;
                end else if (funct == FN_JR) begin
                    cls     = CLS_JR;
                    rs_used = 1'b1;
                end
            end
            OP_ORI, OP_SLTIU, OP_LUI: begin
                cls     = CLS_IMM;
                rs_used = (op != OP_LUI);
                rs_tuse = 2'd1;
                dst_d   = instr_d[20:16];
                tnew_d  = 2'd1;
            end
            OP_BEQ: begin
                cls     = CLS_BRANCH;
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            OP_LW: begin
                cls     = CLS_LOAD;
                rs_used = 1'b1;
                rs_tuse = 2'd1;
                dst_d   = instr_d[20:16];
                tnew_d  = 2'd2;
            end
            OP_JAL: begin
                cls     = CLS_JAL;
                dst_d   = 5'd31;
            end
            OP_SW: begin
                cls     = CLS_STORE;
                rs_used = 1'b1;
                rt_used = 1'b1;
                rs_tuse = 2'd1;
                rt_tuse = 2'd2;
            end
            OP_J:    cls = CLS_J;
            default: cls = CLS_OTHER;
        endcase
    end

    // Returns {stall, sel}. Scanning oldest to youngest lets the youngest match win.
    function automatic logic [FWD_W:0] check_operand(
        input logic [4:0]              r,
        input logic                    used,
        input logic [1:0]              tuse,
        input stage_t [NUM_STAGES-1:0] stages
    );
        logic             hit;
        stage_t           m;
        logic [FWD_W-1:0] k_sel;
        hit   = 1'b0;
        m     = '0;
        k_sel = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stages[k].dst == r) begin
                hit   = 1'b1;
                m     = stages[k];
                k_sel = FWD_W'(k + 1);
            end
        end
        if (!used || r == 5'd0 || !hit) return '0;
        if (m.rem > tuse) return {1'b1, {FWD_W{1'b0}}};
        return {1'b0, (m.rem == 2'd0) ? k_sel : {FWD_W{1'b0}}};
    endfunction

    logic [FWD_W:0] rs_chk;
    logic [FWD_W:0] rt_chk;

    // stall is raw: the consumer combines it with hold if it needs a gated enable.
    always_comb begin
        rs_chk     = check_operand(instr_d[25:21], rs_used, rs_tuse, stage_q);
        rt_chk     = check_operand(instr_d[20:16], rt_used, rt_tuse, stage_q);
        stall      = rs_chk[FWD_W] | rt_chk[FWD_W];
        fwd_rs_sel = rs_chk[FWD_W-1:0];
        fwd_rt_sel = rt_chk[FWD_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else if (!hold) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                stage_q[k].dst <= stage_q[k-1].dst;
                stage_q[k].rem <= (stage_q[k-1].rem == 2'd0) ? 2'd0 : stage_q[k-1].rem - 2'd1;
            end
            if (stall) begin
                stage_q[0] <= '0;
            end else begin
                stage_q[0].dst <= dst_d;
                stage_q[0].rem <= tnew_d;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard pairs plus random instruction streams
// checked against a list-of-stages reference model.
module tb_hazard_scoreboard;

    localparam int NS = 3;
    localparam int FW = $clog2(NS + 1);
    localparam logic [31:0] OTHER = 32'hFC00_0000;

    logic          clk;
    logic          reset;
    logic [31:0]   instr_d;
    logic          hold;
    logic [3:0]    class_d;
    logic          stall;
    logic [FW-1:0] fwd_rs_sel;
    logic [FW-1:0] fwd_rt_sel;

    int errors = 0;
    int checks = 0;

    int m_dst [NS+1];
    int m_rem [NS+1];

    hazard_scoreboard #(.NUM_STAGES(NS)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_d    (instr_d),
        .hold       (hold),
        .class_d    (class_d),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction encoders
    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // reference model: tuse < 0 means operand unused
    function automatic void ref_decode(input logic [31:0] ins, output int cls,
                                       output int rs_tu, output int rt_tu,
                                       output int dst, output int tnew);
        cls = 0; rs_tu = -1; rt_tu = -1; dst = 0; tnew = 0;
        case (ins[31:26])
            6'h00: begin
                if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23) begin
                    cls = 1; rs_tu = 1; rt_tu = 1; dst = int'(ins[15:11]); tnew = 1;
                end else if (ins[5:0] == 6'h00) begin
                    cls = 1; rt_tu = 1; dst = int'(ins[15:11]); tnew = 1;
                end else if (ins[5:0] == 6'h08) begin
                    cls = 5; rs_tu = 0;
                end
            end
            6'h0d, 6'h0b: begin cls = 2; rs_tu = 1; dst = int'(ins[20:16]); tnew = 1; end
            6'h0f:        begin cls = 2; dst = int'(ins[20:16]); tnew = 1; end
            6'h04:        begin cls = 3; rs_tu = 0; rt_tu = 0; end
            6'h23:        begin cls = 4; rs_tu = 1; dst = int'(ins[20:16]); tnew = 2; end
            6'h03:        begin cls = 6; dst = 31; tnew = 0; end
            6'h2b:        begin cls = 7; rs_tu = 1; rt_tu = 2; end
            6'h02:        cls = 8;
            default:      cls = 0;
        endcase
    endfunction

    function automatic void ref_operand(input int r, input int tu, output int st, output int sel);
        st = 0; sel = 0;
        if (tu < 0 || r == 0) return;
        for (int k = 1; k <= NS; k++) begin
            if (m_dst[k] == r) begin
                if (m_rem[k] > tu) st = 1;
                else if (m_rem[k] == 0) sel = k;
                return;
            end
        end
    endfunction

    function automatic void ref_eval(input logic [31:0] ins, output int cls, output int st,
                                     output int rs_sel, output int rt_sel,
                                     output int dst, output int tnew);
        int rs_tu, rt_tu, st_a, st_b;
        ref_decode(ins, cls, rs_tu, rt_tu, dst, tnew);
        ref_operand(int'(ins[25:21]), rs_tu, st_a, rs_sel);
        ref_operand(int'(ins[20:16]), rt_tu, st_b, rt_sel);
        st = (st_a != 0 || st_b != 0) ? 1 : 0;
    endfunction

    // driver tasks: inputs change on the falling edge and are sampled 1 time unit later
    task automatic drive(input logic [31:0] ins, input logic h, input logic r);
        @(negedge clk);
        instr_d = ins;
        hold    = h;
        reset   = r;
        #1;
    endtask

    task automatic clk_edge();
        int cls, st, rs_sel, rt_sel, dst, tnew;
        logic r, h;
        ref_eval(instr_d, cls, st, rs_sel, rt_sel, dst, tnew);
        r = reset;
        h = hold;
        @(posedge clk);
        if (r) begin
            for (int k = 1; k <= NS; k++) begin m_dst[k] = 0; m_rem[k] = 0; end
        end else if (!h) begin
            for (int k = NS; k >= 2; k--) begin
                m_dst[k] = m_dst[k-1];
                m_rem[k] = (m_rem[k-1] > 0) ? m_rem[k-1] - 1 : 0;
            end
            m_dst[1] = st ? 0 : dst;
            m_rem[1] = st ? 0 : tnew;
        end
    endtask

    task automatic flush();
        for (int i = 0; i <= NS; i++) begin
            drive(OTHER, 1'b0, 1'b0);
            clk_edge();
        end
    endtask

    function automatic logic [4:0] rand_reg();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd2;
            3:       return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        a = rand_reg(); b = rand_reg(); c = rand_reg();
        case ($urandom_range(0, 13))
            0:       return enc_r(6'h21, a, b, c);
            1:       return enc_r(6'h23, a, b, c);
            2:       return enc_r(6'h00, a, b, c);
            3:       return enc_i(6'h0d, a, b, 16'($urandom));
            4:       return enc_i(6'h0b, a, b, 16'($urandom));
            5:       return enc_i(6'h0f, a, b, 16'($urandom));
            6:       return enc_i(6'h04, a, b, 16'($urandom));
            7:       return enc_i(6'h23, a, b, 16'($urandom));
            8:       return enc_r(6'h08, a, 5'd0, 5'd0);
            9:       return {6'h03, 26'($urandom)};
            10:      return enc_i(6'h2b, a, b, 16'($urandom));
            11:      return {6'h02, 26'($urandom)};
            12:      return {6'h3e, a, b, c, 11'd0};
            default: return enc_r(6'h3f, a, b, c);
        endcase
    endfunction

    task automatic test_reset();
        drive(OTHER, 1'b0, 1'b1);
        clk_edge();
        clk_edge();
        drive(enc_r(6'h21, 5'd1, 5'd1, 5'd1), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall); end
        checks++; if (fwd_rs_sel !== '0) begin errors++; $display("FAIL reset_rs_sel: got %0d expected 0", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== '0) begin errors++; $display("FAIL reset_rt_sel: got %0d expected 0", fwd_rt_sel); end
        clk_edge();
    endtask

    task automatic test_classes();
        logic [31:0] ins [10];
        int          exp [10];
        ins[0] = enc_r(6'h21, 5'd0, 5'd0, 5'd0);  exp[0] = 1;
        ins[1] = enc_i(6'h0d, 5'd0, 5'd0, 16'd5); exp[1] = 2;
        ins[2] = enc_i(6'h04, 5'd0, 5'd0, 16'd1); exp[2] = 3;
        ins[3] = enc_i(6'h23, 5'd0, 5'd0, 16'd0); exp[3] = 4;
        ins[4] = enc_r(6'h08, 5'd0, 5'd0, 5'd0);  exp[4] = 5;
        ins[5] = {6'h03, 26'd100};                exp[5] = 6;
        ins[6] = enc_i(6'h2b, 5'd0, 5'd0, 16'd0); exp[6] = 7;
        ins[7] = {6'h02, 26'd7};                  exp[7] = 8;
        ins[8] = {6'h3e, 26'h3ff_ffff};           exp[8] = 0;
        ins[9] = enc_r(6'h2a, 5'd1, 5'd2, 5'd3);  exp[9] = 0;
        flush();
        for (int i = 0; i < 10; i++) begin
            drive(ins[i], 1'b0, 1'b0);
            checks++;
            if (class_d !== 4'(exp[i])) begin
                errors++; $display("FAIL class_%0d: got %0d expected %0d", i, class_d, exp[i]);
            end
            clk_edge();
        end
    endtask

    task automatic test_pair_a();
        flush();
        drive(enc_i(6'h23, 5'd0, 5'd1, 16'd0), 1'b0, 1'b0);
        clk_edge();
        drive(enc_r(6'h21, 5'd1, 5'd3, 5'd2), 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL a_stall1: got %0d expected 1", stall); end
        clk_edge();
        drive(enc_r(6'h21, 5'd1, 5'd3, 5'd2), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL a_stall2: got %0d expected 0", stall); end
        checks++; if (fwd_rs_sel !== 0) begin errors++; $display("FAIL a_rs_sel: got %0d expected 0", fwd_rs_sel); end
        clk_edge();
        // the load result has moved to stage 3 with rem 0
        drive(enc_i(6'h04, 5'd1, 5'd0, 16'd0), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL a_beq_stall: got %0d expected 0", stall); end
        checks++; if (fwd_rs_sel !== 3) begin errors++; $display("FAIL a_beq_rs_sel: got %0d expected 3", fwd_rs_sel); end
        clk_edge();
    endtask

    task automatic test_pair_b();
        flush();
        drive(enc_r(6'h21, 5'd5, 5'd6, 5'd4), 1'b0, 1'b0);
        clk_edge();
        drive(enc_i(6'h04, 5'd4, 5'd0, 16'd3), 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b_stall1: got %0d expected 1", stall); end
        clk_edge();
        drive(enc_i(6'h04, 5'd4, 5'd0, 16'd3), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b_stall2: got %0d expected 0", stall); end
        checks++; if (fwd_rs_sel !== 2) begin errors++; $display("FAIL b_rs_sel: got %0d expected 2", fwd_rs_sel); end
        clk_edge();
    endtask

    task automatic test_pairs_cde();
        flush();
        drive({6'h03, 26'd64}, 1'b0, 1'b0);
        clk_edge();
        drive(enc_r(6'h08, 5'd31, 5'd0, 5'd0), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL c_stall: got %0d expected 0", stall); end
        checks++; if (fwd_rs_sel !== 1) begin errors++; $display("FAIL c_rs_sel: got %0d expected 1", fwd_rs_sel); end
        clk_edge();
        flush();
        drive(enc_i(6'h0d, 5'd1, 5'd0, 16'd5), 1'b0, 1'b0);
        clk_edge();
        drive(enc_r(6'h21, 5'd0, 5'd0, 5'd2), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL d_stall: got %0d expected 0", stall); end
        checks++; if (fwd_rs_sel !== 0) begin errors++; $display("FAIL d_rs_sel: got %0d expected 0", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 0) begin errors++; $display("FAIL d_rt_sel: got %0d expected 0", fwd_rt_sel); end
        clk_edge();
        flush();
        drive(enc_i(6'h23, 5'd0, 5'd7, 16'd0), 1'b0, 1'b0);
        clk_edge();
        drive(enc_i(6'h2b, 5'd8, 5'd7, 16'd0), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL e_stall: got %0d expected 0", stall); end
        checks++; if (fwd_rt_sel !== 0) begin errors++; $display("FAIL e_rt_sel: got %0d expected 0", fwd_rt_sel); end
        clk_edge();
    endtask

    task automatic test_hold();
        flush();
        drive(enc_i(6'h23, 5'd0, 5'd1, 16'd0), 1'b0, 1'b0);
        clk_edge();
        for (int i = 0; i < 3; i++) begin
            drive(enc_r(6'h21, 5'd1, 5'd3, 5'd2), 1'b1, 1'b0);
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall_%0d: got %0d expected 1", i, stall); end
            clk_edge();
        end
        drive(enc_r(6'h21, 5'd1, 5'd3, 5'd2), 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_release: got %0d expected 1", stall); end
        clk_edge();
        drive(enc_r(6'h21, 5'd1, 5'd3, 5'd2), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_resolved: got %0d expected 0", stall); end
        clk_edge();
    endtask

    task automatic test_reset_mid_stall();
        flush();
        drive(enc_i(6'h23, 5'd0, 5'd1, 16'd0), 1'b0, 1'b0);
        clk_edge();
        drive(enc_r(6'h21, 5'd1, 5'd3, 5'd2), 1'b0, 1'b1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_before: got %0d expected 1", stall); end
        clk_edge();
        drive(enc_r(6'h21, 5'd1, 5'd1, 5'd2), 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got %0d expected 0", stall); end
        checks++; if (fwd_rs_sel !== 0) begin errors++; $display("FAIL rst_mid_rs_sel: got %0d expected 0", fwd_rs_sel); end
        clk_edge();
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic        h, r;
        int          cls, st, rs_sel, rt_sel, dst, tnew;
        ins = rand_instr();
        for (int n = 0; n < 600; n++) begin
            h = ($urandom_range(0, 99) < 8);
            r = ($urandom_range(0, 99) < 2);
            drive(ins, h, r);
            ref_eval(ins, cls, st, rs_sel, rt_sel, dst, tnew);
            checks++; if (class_d !== 4'(cls)) begin errors++; $display("FAIL rnd_class[%0d]: got %0d expected %0d instr %h", n, class_d, cls, ins); end
            checks++; if (stall !== 1'(st)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d instr %h", n, stall, st, ins); end
            checks++; if (fwd_rs_sel !== FW'(rs_sel)) begin errors++; $display("FAIL rnd_rs_sel[%0d]: got %0d expected %0d instr %h", n, fwd_rs_sel, rs_sel, ins); end
            checks++; if (fwd_rt_sel !== FW'(rt_sel)) begin errors++; $display("FAIL rnd_rt_sel[%0d]: got %0d expected %0d instr %h", n, fwd_rt_sel, rt_sel, ins); end
            clk_edge();
            // a stalled or held D stage keeps its instruction
            if (r || !(h || st != 0)) ins = rand_instr();
        end
    endtask

    initial begin
        for (int k = 0; k <= NS; k++) begin m_dst[k] = 0; m_rem[k] = 0; end
        reset   = 1'b1;
        hold    = 1'b0;
        instr_d = OTHER;
        test_reset();
        test_classes();
        test_pair_a();
        test_pair_b();
        test_pairs_cde();
        test_hold();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the instruction-class decoder: classifies the D-stage MIPS instruction and tracks destination registers of NUM_STAGES in-flight stages (stage 1 = E, 2 = M, 3 = W).
- Produces the D-stage stall and D-stage operand forwarding selects using Tuse/Tnew rules.
- Sits beside the D/E pipeline register and drives its enable and bubble insertion.

Parameters:
- NUM_STAGES, 3, number of tracked stages after D; legal values are 2 or more.
- FWD_W, $clog2(NUM_STAGES+1), width of the forwarding selects; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instr_d  in  32  D-stage instruction word
- hold  in  1  external freeze (e.g. memory busy); all stages hold
- class_d  out  4  0 other, 1 R, 2 imm, 3 branch, 4 load, 5 jr, 6 jal, 7 store, 8 j
- stall  out  1  freeze PC/F/D and insert a bubble into stage 1
- fwd_rs_sel  out  FWD_W  0 = register file, k = value from stage k
- fwd_rt_sel  out  FWD_W  same encoding, for rt

Behaviour:
Class table (op, funct). Each entry gives rs Tuse, rt Tuse, destination, Tnew. "-" means the operand or destination is unused.
- R (special: addu, subu, sll): rs 1, rt 1, dst rd, Tnew 1. sll uses no rs.
- imm (ori, sltiu, lui): rs 1, dst rt, Tnew 1. lui uses no rs.
- branch (beq): rs 0, rt 0, no dst.
- load (lw): rs 1, dst rt, Tnew 2.
- jr (special, funct 001000): rs 0, no dst.
- jal: dst 31, Tnew 0.
- store (sw): rs 1, rt 2, no dst.
- j: no operands, no dst.
- other (0): no operands, no dst.

Classification and stall/forwarding logic are combinational from instr_d and the stage state.

State:
- Each stage k holds {dst[4:0], rem[1:0]}.
- A bubble is dst = 0.
- Reset clears every stage to a bubble. stall, fwd_rs_sel and fwd_rt_sel are then 0 in the first cycle after reset.

Per clock edge, in priority order:
- reset: all stages become bubbles.
- hold: all stages keep their values.
- Otherwise:
  - Stage k+1 takes stage k with rem' = (rem == 0) ? 0 : rem - 1.
  - Stage 1 takes {dst_d, Tnew_d} when stall = 0; otherwise it takes a bubble.
  - The entry in stage NUM_STAGES is discarded.

Hazard check, per used operand r (rs or rt) with r != 0:
- Find the lowest k (youngest stage) with dst_k == r.
- If rem_k > Tuse_r, the operand stalls.
- Otherwise, fwd_sel = k if rem_k == 0, else 0.
- If no stage matches, or the operand is unused or $0: no stall and sel = 0.

Outputs:
- stall = OR of both operand stalls.
- Both fwd selects are still reported while stall = 1.
- stall is not masked by hold. The consumer ANDs it if required.

Boundaries:
- Duplicate dst in several stages: only the youngest matters.
- rem saturates at 0, never wraps.
- Stage 1 with dst 0 never hazards.
- Unknown opcode gives class 0, no hazard.
- Reset asserted mid-stall clears the stall on the next edge.

Test Plan:
- Hazard pair A: lw $1 in D, then addu $2,$1,$3.
  - stall = 1 for exactly 1 cycle.
  - Next cycle stall = 0, fwd_rs_sel = 0; stage 2 then holds $1 with rem 1.
- Hazard pair B: addu $4,$5,$6, then beq $4,$0.
  - stall = 1 for 1 cycle (rem 1 > Tuse 0).
  - Then stall = 0 with fwd_rs_sel = 2.
- Pair C: jal, then jr $31.
  - No stall; fwd_rs_sel = 1.
- Pair D: ori $0,$1,5, then addu $2,$0,$0.
  - No stall; both selects 0.
- Pair E: lw $7, then sw $7,0($8).
  - rt Tuse 2 ≥ rem 2, so no stall; fwd_rt_sel = 0.
- hold = 1 for 3 cycles during a lw dependency.
  - Stage contents unchanged and stall stays 1.
  - After release, resolves in 1 cycle.
- reset pulsed while stall = 1.
  - Next cycle all stages are bubbles and stall = 0.
